// File: rtl/mem_access_unit.sv
// RV32 memory-access stage with MEM/WB register: drives a req/gnt/rvalid data bus,
// stalls EX/MEM for the duration of each access, aligns lanes and reports misalign/timeout.
module mem_access_unit #(
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid_i,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   input  logic [31:0]       wdata_i,
   input  logic [1:0]        rw_i,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       sdata_i,
   output logic              stall_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_sel_o,
   output logic [31:0]       bus_wdata_o,
   input  logic              bus_gnt_i,
   input  logic              bus_rvalid_i,
   input  logic [31:0]       bus_rdata_i,
   output logic              wb_valid_o,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic [31:0]       wdata_o,
   output logic              misalign_o,
   output logic              fault_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               ld_q;
   logic [2:0]         f3_q;
   logic [1:0]         off_q;
   logic [4:0]         wd_l_q;
   logic               wreg_l_q;

   logic               is_st, is_ld, is_mem, misal, accept;
   logic               tmo_hit, done_st, gnt_ld, done_ld, tmo;
   logic [3:0]         sel_in;
   logic [31:0]        wdat_in;
   logic [7:0]         rbyte;
   logic [15:0]        rhalf;
   logic [31:0]        ld_val;

   // Request decode; funct3[1:0]=11 is handled as a word access.
   always_comb begin
      is_st  = (rw_i == 2'b01);
      is_ld  = (rw_i == 2'b10);
      is_mem = ex_valid_i & (is_st | is_ld);
      misal  = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
               (funct3_i[1] & (addr_i[1:0] != 2'b00));
      accept = (state_q == S_IDLE) & is_mem & ~misal;
      case (funct3_i[1:0])
         2'b00:   begin sel_in = 4'b0001 << addr_i[1:0]; wdat_in = {4{sdata_i[7:0]}};  end
         2'b01:   begin sel_in = 4'b0011 << addr_i[1:0]; wdat_in = {2{sdata_i[15:0]}}; end
         default: begin sel_in = 4'b1111;                wdat_in = sdata_i;            end
      endcase
   end

   always_comb begin
      tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
      done_st = (state_q == S_REQ) & bus_gnt_i & ~ld_q;
      gnt_ld  = (state_q == S_REQ) & bus_gnt_i & ld_q;
      done_ld = (state_q == S_WAIT) & bus_rvalid_i;
      // A completing store/load beats the timeout; a load grant is not a completion.
      tmo     = (state_q != S_IDLE) & tmo_hit & ~(done_st | done_ld);
   end

   always_comb begin
      rbyte = bus_rdata_i[{off_q, 3'b000} +: 8];
      rhalf = bus_rdata_i[{off_q[1], 4'b0000} +: 16];
      case (f3_q)
         3'b000:  ld_val = {{24{rbyte[7]}}, rbyte};
         3'b100:  ld_val = {24'b0, rbyte};
         3'b001:  ld_val = {{16{rhalf[15]}}, rhalf};
         3'b101:  ld_val = {16'b0, rhalf};
         default: ld_val = bus_rdata_i;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_REQ;
         S_REQ: begin
            if (tmo || done_st) state_d = S_IDLE;
            else if (gnt_ld)    state_d = S_WAIT;
         end
         S_WAIT: if (tmo || done_ld) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      cnt_d = (state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
   end

   always_comb begin
      stall_o = 1'b0;
      case (state_q)
         S_IDLE:  stall_o = accept;
         S_REQ:   stall_o = ~(done_st | tmo);
         S_WAIT:  stall_o = ~(done_ld | tmo);
         default: stall_o = 1'b0;
      endcase
   end

   // Bus request registers and access context latched at acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_sel_o   <= '0;
         bus_wdata_o <= '0;
         ld_q        <= 1'b0;
         f3_q        <= '0;
         off_q       <= '0;
         wd_l_q      <= '0;
         wreg_l_q    <= 1'b0;
      end else if (accept) begin
         bus_req_o   <= 1'b1;
         bus_we_o    <= is_st;
         bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
         bus_sel_o   <= sel_in;
         bus_wdata_o <= wdat_in;
         ld_q        <= is_ld;
         f3_q        <= funct3_i;
         off_q       <= addr_i[1:0];
         wd_l_q      <= wd_i;
         wreg_l_q    <= wreg_i;
      end else if (state_q == S_REQ && (bus_gnt_i || tmo)) begin
         bus_req_o   <= 1'b0;
      end
   end

   // MEM/WB register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_o <= 1'b0;
         wd_o       <= '0;
         wreg_o     <= 1'b0;
         wdata_o    <= '0;
         misalign_o <= 1'b0;
         fault_o    <= 1'b0;
      end else begin
         misalign_o <= 1'b0;
         fault_o    <= 1'b0;
         if (state_q == S_IDLE) begin
            if (is_mem && misal) begin
               wb_valid_o <= 1'b1;
               wd_o       <= wd_i;
               wreg_o     <= 1'b0;
               wdata_o    <= wdata_i;
               misalign_o <= 1'b1;
            end else if (accept) begin
               wb_valid_o <= 1'b0;
               wreg_o     <= 1'b0;
            end else begin
               wb_valid_o <= ex_valid_i;
               wd_o       <= wd_i;
               wreg_o     <= wreg_i & ex_valid_i;
               wdata_o    <= wdata_i;
            end
         end else if (tmo) begin
            wb_valid_o <= 1'b1;
            wd_o       <= wd_l_q;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            fault_o    <= 1'b1;
         end else if (done_st) begin
            wb_valid_o <= 1'b1;
            wd_o       <= wd_l_q;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
         end else if (done_ld) begin
            wb_valid_o <= 1'b1;
            wd_o       <= wd_l_q;
            wreg_o     <= wreg_l_q;
            wdata_o    <= ld_val;
         end else begin
            wb_valid_o <= 1'b0;
            wreg_o     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: transaction-level model of retirements and bus
// requests checked every cycle, plus literal expectations from hand-computed cases.
module tb_mem_access_unit;
   localparam int AW = 12;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_valid_i, wreg_i, bus_gnt_i, bus_rvalid_i;
   logic [4:0]    wd_i;
   logic [31:0]   wdata_i, sdata_i, bus_rdata_i;
   logic [1:0]    rw_i;
   logic [2:0]    funct3_i;
   logic [AW-1:0] addr_i;
   logic          stall_o, bus_req_o, bus_we_o, wb_valid_o, wreg_o, misalign_o, fault_o;
   logic [AW-1:0] bus_addr_o;
   logic [3:0]    bus_sel_o;
   logic [31:0]   bus_wdata_o, wdata_o;
   logic [4:0]    wd_o;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .wdata_i(wdata_i), .rw_i(rw_i), .funct3_i(funct3_i), .addr_i(addr_i),
      .sdata_i(sdata_i), .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
      .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
      .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
      .wb_valid_o(wb_valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .misalign_o(misalign_o), .fault_o(fault_o)
   );

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        mis;
      logic        flt;
   } ret_t;

   ret_t          exq[$];
   int            checks = 0;
   int            errors = 0;
   logic          run = 1'b0;
   logic          exp_req = 1'b0;
   logic [AW-1:0] exp_addr;
   logic [3:0]    exp_sel;
   logic [31:0]   exp_bwd;
   logic          exp_we;

   logic [AW-1:0] cap_addr;
   logic [3:0]    cap_sel;
   logic [31:0]   cap_bwd;
   logic          cap_we;
   logic [4:0]    last_wd;
   logic          last_wreg, last_mis, last_flt;
   logic [31:0]   last_wdata;
   int            lat;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input int o, input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * o)) & 32'hFF;
      h = (rd >> (16 * (o / 2))) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 128) ? (b | 32'hFFFFFF00) : b;
         3'b100:  return b;
         3'b001:  return (h >= 32768) ? (h | 32'hFFFF0000) : h;
         3'b101:  return h;
         default: return rd;
      endcase
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_wb_valid"}, wb_valid_o, 0);
      chk({tag, "_wd"}, wd_o, 0);
      chk({tag, "_wreg"}, wreg_o, 0);
      chk({tag, "_wdata"}, wdata_o, 0);
      chk({tag, "_misalign"}, misalign_o, 0);
      chk({tag, "_fault"}, fault_o, 0);
      chk({tag, "_bus_req"}, bus_req_o, 0);
      chk({tag, "_bus_we"}, bus_we_o, 0);
      chk({tag, "_bus_addr"}, 32'(bus_addr_o), 0);
      chk({tag, "_bus_sel"}, 32'(bus_sel_o), 0);
      chk({tag, "_bus_wdata"}, bus_wdata_o, 0);
   endtask

   task automatic idle_inputs();
      ex_valid_i = 1'b0; rw_i = 2'b00; wreg_i = 1'b0;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; exp_req = 1'b0;
   endtask

   // Present one instruction at posedge+1 and script the bus; gd = REQ cycles before gnt,
   // rd = WAIT cycles before rvalid. Returns latency to WB valid.
   task automatic do_op(input logic ev, input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                        input logic [1:0] rw, input logic [2:0] f3, input logic [AW-1:0] addr,
                        input logic [31:0] sdat, input int gd, input int rd, input logic [31:0] rdat);
      int   n, cl, endc, o;
      logic mem, mis, al, ld, flt;
      ret_t e;
      n    = nbytes(f3);
      o    = int'(addr % 4);
      ld   = (rw == 2'b10);
      mem  = ev && (rw == 2'b01 || rw == 2'b10);
      mis  = mem && ((addr % n) != 0);
      al   = mem && !mis;
      cl   = !al ? 0 : (ld ? 2 + gd + rd : 1 + gd);
      flt  = al && (TO != 0) && (cl > TO);
      endc = flt ? TO : cl;
      if (ev) begin
         e.wd    = wd;
         e.mis   = mis;
         e.flt   = flt;
         e.wreg  = (mis || flt || (al && !ld)) ? 1'b0 : wr;
         e.wdata = (al && ld) ? m_load(f3, o, rdat) : wdat;
         exq.push_back(e);
      end
      exp_addr = AW'((addr / 4) * 4);
      exp_sel  = 4'(((1 << n) - 1) << o);
      exp_bwd  = (n == 1) ? sdat[7:0] * 32'h01010101 : (n == 2) ? sdat[15:0] * 32'h00010001 : sdat;
      exp_we   = !ld;
      cap_addr = '0; cap_sel = '0; cap_bwd = '0; cap_we = 1'b0;
      ex_valid_i = ev; wd_i = wd; wreg_i = wr; wdata_i = wdat; rw_i = rw;
      funct3_i = f3; addr_i = addr; sdata_i = sdat;
      for (int l = 0; l <= endc; l++) begin
         exp_req   = al && l >= 1 && l <= 1 + gd;
         bus_gnt_i = al && l == 1 + gd;
         if (ld && al && l == cl) begin
            bus_rvalid_i = 1'b1; bus_rdata_i = rdat;
         end else if (al && l == 1) begin
            bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
         end else begin
            bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
         end
         if (l == 1) begin
            addr_i = addr ^ 12'h5A5; wd_i = wd ^ 5'h1F; sdata_i = ~sdat;
            funct3_i = f3 ^ 3'b100; wreg_i = ~wr;
         end
         @(negedge clk);
         chk("stall", stall_o, al && l < endc);
         if (bus_req_o) begin
            cap_addr = bus_addr_o; cap_sel = bus_sel_o; cap_bwd = bus_wdata_o; cap_we = bus_we_o;
         end
         @(posedge clk); #1;
         if (l < endc) chk("early_wb", wb_valid_o, 0);
      end
      chk("wb_latency", wb_valid_o, ev);
      lat = endc + 1;
      last_wd = wd_o; last_wreg = wreg_o; last_wdata = wdata_o;
      last_mis = misalign_o; last_flt = fault_o;
      idle_inputs();
   endtask

   // Per-cycle compare against the transaction model.
   always @(negedge clk) begin
      if (run && !rst) begin
         chk("bus_req", bus_req_o, exp_req);
         if (exp_req && bus_req_o) begin
            chk("bus_addr", 32'(bus_addr_o), 32'(exp_addr));
            chk("bus_sel", 32'(bus_sel_o), 32'(exp_sel));
            chk("bus_wdata", bus_wdata_o, exp_bwd);
            chk("bus_we", bus_we_o, exp_we);
         end
         if (wb_valid_o) begin
            if (exq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wb_unexpected actual=1 required=0");
            end else begin
               ret_t e;
               e = exq.pop_front();
               chk("wd", wd_o, e.wd);
               chk("wreg", wreg_o, e.wreg);
               chk("misalign", misalign_o, e.mis);
               chk("fault", fault_o, e.flt);
               if (e.wreg) chk("wdata", wdata_o, e.wdata);
            end
         end else begin
            chk("wreg_idle", wreg_o, 0);
            chk("misalign_idle", misalign_o, 0);
            chk("fault_idle", fault_o, 0);
         end
      end
   end

   initial begin
      rst = 1'b1;
      wd_i = '0; wdata_i = '0; funct3_i = '0; addr_i = '0; sdata_i = '0; bus_rdata_i = '0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      chk("reset_stall", stall_o, 0);
      rst = 1'b0;
      run = 1'b1;

      do_op(1, 5'd5, 1, 32'h1234, 2'b00, 3'b000, 12'h000, 0, 0, 0, 0);
      chk("tp_alu_wd", last_wd, 5);
      chk("tp_alu_wreg", last_wreg, 1);
      chk("tp_alu_wdata", last_wdata, 32'h1234);
      do_op(0, 5'd9, 1, 32'h55, 2'b10, 3'b010, 12'h004, 0, 0, 0, 0);
      do_op(1, 5'd3, 1, 32'h77, 2'b11, 3'b010, 12'h003, 0, 0, 0, 0);

      do_op(1, 5'd8, 1, 32'h0, 2'b01, 3'b000, 12'h013, 32'hAB, 2, 0, 0);
      chk("tp_sb_addr", 32'(cap_addr), 32'h010);
      chk("tp_sb_sel", 32'(cap_sel), 32'b1000);
      chk("tp_sb_wdata", cap_bwd, 32'hABABABAB);
      chk("tp_sb_we", cap_we, 1);
      chk("tp_sb_wreg", last_wreg, 0);
      chk("tp_sb_lat", lat, 4);
      do_op(1, 5'd2, 1, 32'h0, 2'b01, 3'b001, 12'h002, 32'h12345678, 0, 0, 0);
      chk("tp_sh_sel", 32'(cap_sel), 32'b1100);
      chk("tp_sh_wdata", cap_bwd, 32'h56785678);
      do_op(1, 5'd4, 1, 32'h0, 2'b01, 3'b010, 12'h008, 32'hCAFEF00D, 3, 0, 0);

      do_op(1, 5'd10, 1, 32'h0, 2'b10, 3'b000, 12'h002, 0, 0, 0, 32'h00800000);
      chk("tp_lb", last_wdata, 32'hFFFFFF80);
      chk("tp_lb_lat", lat, 3);
      do_op(1, 5'd11, 1, 32'h0, 2'b10, 3'b100, 12'h002, 0, 0, 0, 32'h00800000);
      chk("tp_lbu", last_wdata, 32'h00000080);
      do_op(1, 5'd12, 1, 32'h0, 2'b10, 3'b101, 12'h002, 0, 1, 1, 32'hBEEF0000);
      chk("tp_lhu", last_wdata, 32'h0000BEEF);
      do_op(1, 5'd13, 1, 32'h0, 2'b10, 3'b001, 12'h000, 0, 0, 2, 32'h12348001);
      chk("tp_lh", last_wdata, 32'hFFFF8001);
      do_op(1, 5'd14, 1, 32'h0, 2'b10, 3'b010, 12'h004, 0, 1, 0, 32'h0000CAFE);
      do_op(1, 5'd15, 1, 32'h0, 2'b10, 3'b000, 12'h003, 0, 0, 0, 32'h7F000000);
      chk("tp_lb_top", last_wdata, 32'h0000007F);

      do_op(1, 5'd16, 1, 32'h99, 2'b10, 3'b010, 12'h006, 0, 0, 0, 0);
      chk("tp_lw_mis", last_mis, 1);
      chk("tp_lw_mis_wreg", last_wreg, 0);
      chk("tp_lw_mis_lat", lat, 1);
      do_op(1, 5'd17, 1, 32'h0, 2'b10, 3'b001, 12'h001, 0, 0, 0, 0);
      do_op(1, 5'd18, 1, 32'h0, 2'b01, 3'b010, 12'h00A, 32'h1, 0, 0, 0);

      do_op(1, 5'd19, 1, 32'h0, 2'b10, 3'b010, 12'h010, 0, 10, 0, 32'h1);
      chk("tp_to_fault", last_flt, 1);
      chk("tp_to_wreg", last_wreg, 0);
      chk("tp_to_lat", lat, 5);
      do_op(1, 5'd20, 1, 32'h0, 2'b10, 3'b010, 12'h010, 0, 0, 3, 32'h2);
      do_op(1, 5'd21, 1, 32'h0, 2'b10, 3'b010, 12'h014, 0, 0, 0, 32'h600DF00D);
      chk("tp_after_to", last_wdata, 32'h600DF00D);

      // Reset while waiting for read data, then a late rvalid.
      exp_addr = 12'h020; exp_sel = 4'hF; exp_bwd = 32'h0; exp_we = 1'b0;
      ex_valid_i = 1'b1; rw_i = 2'b10; funct3_i = 3'b010; addr_i = 12'h020;
      wd_i = 5'd7; wreg_i = 1'b1; sdata_i = 32'h0;
      @(posedge clk); #1;
      exp_req = 1'b1; bus_gnt_i = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      run = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus_rvalid_i = 1'b1; bus_rdata_i = 32'h12345678;
      chk_zero("midreset");
      chk("midreset_stall", stall_o, 0);
      run = 1'b1;
      @(posedge clk); #1;
      bus_rvalid_i = 1'b0;
      chk("late_rvalid_wb", wb_valid_o, 0);
      do_op(1, 5'd22, 1, 32'h0, 2'b10, 3'b100, 12'h001, 0, 0, 0, 32'h0000FF00);
      chk("tp_post_rst", last_wdata, 32'h000000FF);

      @(posedge clk); #1;
      chk("queue_empty", exq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
